// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron blocks.
//   CNT_W_DEF : default width of spike counters / rate outputs
//   WIN_W_DEF : default width of window lengths / window timers
//   state_e   : two-state decoder FSM encoding (IDLE, COUNT)
package snn_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

endpackage : snn_pkg

// File: rtl/spike_rate_decoder_window_timer.sv
// window_timer: measures out one counting window at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   run_i      : window enable; low abandons the window, next high cycle is cycle 0
//   len_i      : window length in cycles, sampled on cycle 0 only (0 = 2^WIN_W)
//   last_o     : high during the final cycle (N-1) of the current window
module window_timer
    import snn_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [WIN_W-1:0] len_i,
    output logic             last_o
);

    // rem_q holds the cycles still to go after the current one.
    logic [WIN_W-1:0] rem_q, rem_d, cur_rem;
    // fresh_q marks that the next running cycle is window cycle 0.
    logic             fresh_q, fresh_d;

    always_comb begin
        // len-1 wraps 0 to all-ones, which gives the 2^WIN_W window for free.
        cur_rem = fresh_q ? (len_i - WIN_W'(1)) : rem_q;
        last_o  = run_i && (cur_rem == '0);
        rem_d   = rem_q;
        fresh_d = fresh_q;
        if (!run_i || last_o) begin
            fresh_d = 1'b1;
        end else begin
            fresh_d = 1'b0;
            rem_d   = cur_rem - WIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            fresh_q <= 1'b1;
        end else begin
            rem_q   <= rem_d;
            fresh_q <= fresh_d;
        end
    end

endmodule : window_timer

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts rising edges of a neuron spike line over fixed
// windows and hands each window's count to a consumer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : decoding enable; dropping it abandons the current window
//   spike_in    : spike level (a spike is a 0->1 transition)
//   window_len  : window length in cycles, 0 = 2^WIN_W, sampled at window start
//   rate_out    : count of the last completed window (saturating)
//   rate_valid  : rate_out holds a result not yet taken by the consumer
//   rate_ready  : consumer takes rate_out on a cycle where rate_valid is high
//   overrun     : sticky, a pending result was overwritten; cleared by a handshake
//   busy        : window in progress (FSM in COUNT)
// Handshake: a transfer happens on every rising edge where rate_valid and
// rate_ready are both high; rate_valid never depends combinationally on
// rate_ready, and rate_out is stable while rate_valid is high until a new
// window ends.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             spike_edge, win_end, hs;

    window_timer #(.WIN_W(WIN_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (en),
        .len_i  (window_len),
        .last_o (win_end)
    );

    always_comb begin
        spike_edge = spike_in && !prev_q;
        hs         = valid_q && rate_ready;
        cnt_inc    = (spike_edge && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        // The counter is cleared on window end and whenever en is low, so a
        // new window always begins from zero without a separate load.
        cnt_d      = (!en || win_end) ? '0 : cnt_inc;
        state_d    = en ? ST_COUNT : ST_IDLE;

        rate_d  = rate_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (win_end) begin
            rate_d  = cnt_inc;
            valid_d = 1'b1;
            // Overwriting an untaken result sets the flag; a result that is
            // taken in this same cycle leaves it as it was.
            if (valid_q && !hs) begin
                ovr_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            rate_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= spike_in;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q == ST_COUNT);

endmodule : spike_rate_decoder

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder. CNT_W is set to 7 so that a 256-cycle window
// with a toggling spike line (128 edges) runs into the saturation limit.
module tb_spike_rate_decoder;

    localparam int CNT_W = 7;
    localparam int WIN_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int OW    = CNT_W + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             spike_in = 1'b0;
    logic [WIN_W-1:0] window_len = '0;
    logic [CNT_W-1:0] rate_out;
    logic             rate_valid;
    logic             rate_ready = 1'b0;
    logic             overrun;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    // ---------------- reference model ----------------
    // Tracks position within the window, window length, and edge count in
    // plain integers; after each edge pushes the expected output status.
    logic [OW-1:0] exp_q[$];
    int  m_pos = 0, m_len = 1, m_cnt = 0, m_rate = 0, m_res = 0;
    bit  m_prev = 0, m_valid = 0, m_ovr = 0, m_busy = 0, m_hs, m_end;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos = 0; m_cnt = 0; m_rate = 0; m_prev = 0;
            m_valid = 0; m_ovr = 0; m_busy = 0;
        end else begin
            m_hs  = m_valid && rate_ready;
            m_end = 0;
            if (en) begin
                if (m_pos == 0) m_len = (window_len == 0) ? (1 << WIN_W) : int'(window_len);
                if (spike_in && !m_prev && m_cnt < MAXC) m_cnt++;
                m_pos++;
                if (m_pos == m_len) begin
                    m_end = 1; m_res = m_cnt; m_pos = 0; m_cnt = 0;
                end
            end else begin
                m_pos = 0; m_cnt = 0;
            end
            m_prev = spike_in;
            if (m_end) begin
                if (m_valid && !m_hs) m_ovr = 1;
                m_rate = m_res; m_valid = 1;
            end else if (m_hs) begin
                m_valid = 0; m_ovr = 0;
            end
            m_busy = en;
        end
        exp_q.push_back({m_busy, m_ovr, m_valid, m_rate[CNT_W-1:0]});
    end

    // ---------------- monitor ----------------
    logic [OW-1:0] mon_exp, mon_got;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            if (rst_n) begin
                mon_got = {busy, overrun, rate_valid, rate_out};
                n_tests++;
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL status t=%0t got busy/ovr/valid/rate=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                             $time, mon_got[OW-1], mon_got[OW-2], mon_got[OW-3], mon_got[CNT_W-1:0],
                             mon_exp[OW-1], mon_exp[OW-2], mon_exp[OW-3], mon_exp[CNT_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
    task automatic cyc(input bit e, input bit s, input bit r);
        en = e; spike_in = s; rate_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        cyc(0, 0, 0);
        check("reset_valid", rate_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ovr", overrun, 0);
        check("reset_rate", rate_out, 0);
        cyc(0, 0, 0);
        rst_n = 1'b1;

        // 10-cycle window, three single-cycle spikes
        window_len = 8'd10;
        for (int i = 0; i < 10; i++) begin
            cyc(1, (i == 2 || i == 5 || i == 8), 0);
            check("w1_busy", busy, 1);
            if (i < 9) check("w1_valid_early", rate_valid, 0);
        end
        check("w1_valid", rate_valid, 1);
        check("w1_rate", rate_out, 3);

        // spike held high for 5 cycles counts once; result taken at cycle 0
        for (int i = 0; i < 10; i++) begin
            cyc(1, (i >= 2 && i <= 6), (i == 0));
            if (i == 0) check("w2_taken", rate_valid, 0);
        end
        check("w2_rate", rate_out, 1);
        check("w2_valid", rate_valid, 1);
        cyc(0, 0, 1);
        check("w2_consumed", rate_valid, 0);
        check("idle_busy", busy, 0);

        // overwrite without handshake sets overrun
        window_len = 8'd4;
        for (int i = 0; i < 4; i++) cyc(1, (i == 0 || i == 2), 0);
        check("ovr_a_rate", rate_out, 2);
        check("ovr_a_ovr", overrun, 0);
        for (int i = 0; i < 4; i++) cyc(1, (i == 0), 0);
        check("ovr_b_rate", rate_out, 1);
        check("ovr_b_ovr", overrun, 1);
        check("ovr_b_valid", rate_valid, 1);
        cyc(0, 0, 1);
        check("ovr_clr_valid", rate_valid, 0);
        check("ovr_clr_ovr", overrun, 0);

        // handshake on the window-end cycle: load, stay valid, no overrun
        for (int i = 0; i < 4; i++) cyc(1, (i == 0), 0);
        check("hs_end_first", rate_out, 1);
        for (int i = 0; i < 4; i++) cyc(1, (i == 0 || i == 2), (i == 3));
        check("hs_end_rate", rate_out, 2);
        check("hs_end_valid", rate_valid, 1);
        check("hs_end_ovr", overrun, 0);
        cyc(0, 0, 1);

        // en dropped at window cycle 5 of 10: no result, rate_out kept
        window_len = 8'd10;
        for (int i = 0; i < 5; i++) cyc(1, (i == 1 || i == 3), 0);
        cyc(0, 0, 0);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0);
        check("abort_valid", rate_valid, 0);
        check("abort_rate", rate_out, 2);

        // reset mid-window clears outputs at once
        for (int i = 0; i < 3; i++) cyc(1, (i == 1), 0);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rate", rate_out, 0);
        check("rst_valid", rate_valid, 0);
        check("rst_ovr", overrun, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst_n = 1'b1;
        window_len = 8'd3;
        for (int i = 0; i < 3; i++) cyc(1, (i == 0), 0);
        check("post_rst_rate", rate_out, 1);
        check("post_rst_valid", rate_valid, 1);
        cyc(0, 0, 1);

        // window_len 0 = 256 cycles, toggling spike saturates the count
        window_len = 8'd0;
        for (int i = 0; i < 256; i++) begin
            cyc(1, (i % 2 == 0), 0);
            if (i == 254) check("sat_valid_early", rate_valid, 0);
        end
        check("sat_valid", rate_valid, 1);
        check("sat_rate", rate_out, MAXC);
        cyc(0, 0, 1);

        // randomized traffic, checked by the model each cycle
        window_len = 8'd5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                window_len = ($urandom_range(0, 30) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            cyc(($urandom_range(0, 29) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0));
        end

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spike_rate_decoder
